// File: rtl/riscv_prog_loader.sv
// Byte-stream program loader: parses I/D/G records, writes core memory, runs the core and times the run.
// Define LOADER_DUMP_EN to stream DUMP_LEN data-memory words back out after each run.
module riscv_prog_loader #(
  parameter int unsigned RST_CYCLES = 9,
  parameter logic [15:0] DUMP_BASE  = 16'h0000,
  parameter int unsigned DUMP_LEN   = 16,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        test_normal,
  output logic        ext_inst_we,
  output logic        ext_data_we,
  output logic [15:0] ext_addr,
  output logic [15:0] ext_data,
  output logic        cpu_rst,
  input  logic        done,
  input  logic [15:0] mem_out,
  output logic [31:0] run_cycles,
  output logic        run_valid,
  output logic        busy,
  output logic        err,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  input  logic        out_ready
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, ADDR_H = 4'd1, ADDR_L = 4'd2, DATA_H = 4'd3, DATA_L = 4'd4,
    WRITE = 4'd5, RST_HOLD = 4'd6, RUN = 4'd7, FIN = 4'd8
`ifdef LOADER_DUMP_EN
    , DUMP_ADDR = 4'd9, DUMP_WAIT = 4'd10, DUMP_HI = 4'd11, DUMP_LO = 4'd12
`endif
  } state_e;

  localparam logic [7:0] CMD_I = 8'h49;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_G = 8'h47;

  state_e      state_q, state_d;
  logic        is_inst_q, is_inst_d;
  logic [7:0]  hold_q, hold_d;
  logic        in_ready_q, in_ready_d;
  logic        test_normal_q, test_normal_d;
  logic        inst_we_q, inst_we_d;
  logic        data_we_q, data_we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic [31:0] run_cycles_q, run_cycles_d;
  logic        run_valid_q, run_valid_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        accept_s;
`ifdef LOADER_DUMP_EN
  logic [8:0]  idx_q, idx_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  lo_q, lo_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_byte_q, out_byte_d;
`endif

  assign accept_s = in_valid && in_ready_q;

  // Next-state and next-output computation for the whole loader.
  always_comb begin
    state_d       = state_q;
    is_inst_d     = is_inst_q;
    hold_d        = hold_q;
    test_normal_d = test_normal_q;
    inst_we_d     = 1'b0;
    data_we_d     = 1'b0;
    addr_d        = addr_q;
    data_d        = data_q;
    cpu_rst_d     = cpu_rst_q;
    run_cycles_d  = run_cycles_q;
    run_valid_d   = run_valid_q;
    err_d         = err_q;
`ifdef LOADER_DUMP_EN
    idx_d         = idx_q;
    wait_d        = wait_q;
    lo_d          = lo_q;
    out_valid_d   = out_valid_q;
    out_byte_d    = out_byte_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if ((in_byte == CMD_I) || (in_byte == CMD_D)) begin
            is_inst_d     = (in_byte == CMD_I);
            cpu_rst_d     = 1'b0;
            test_normal_d = 1'b1;
            state_d       = ADDR_H;
          end else if (in_byte == CMD_G) begin
            run_valid_d   = 1'b0;
            test_normal_d = 1'b0;
            cpu_rst_d     = 1'b0;
            hold_d        = 8'(RST_CYCLES);
            state_d       = RST_HOLD;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ADDR_H: begin
        if (accept_s) begin addr_d[15:8] = in_byte; state_d = ADDR_L; end
        else begin state_d = ADDR_H; end
      end
      ADDR_L: begin
        if (accept_s) begin addr_d[7:0] = in_byte; state_d = DATA_H; end
        else begin state_d = ADDR_L; end
      end
      DATA_H: begin
        if (accept_s) begin data_d[15:8] = in_byte; state_d = DATA_L; end
        else begin state_d = DATA_H; end
      end
      DATA_L: begin
        if (accept_s) begin
          data_d[7:0] = in_byte;
          inst_we_d   = is_inst_q;
          data_we_d   = !is_inst_q;
          state_d     = WRITE;
        end else begin
          state_d = DATA_L;
        end
      end
      WRITE: state_d = IDLE;
      RST_HOLD: begin
        // The counter starts at RST_CYCLES, so cpu_rst is low for exactly that many cycles.
        if (hold_q <= 8'd1) begin
          cpu_rst_d    = 1'b1;
          run_cycles_d = 32'd0;
          state_d      = RUN;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      RUN: begin
        if (done) begin
          run_valid_d = 1'b1;
          state_d     = FIN;
        end else if (run_cycles_q != 32'hFFFF_FFFF) begin
          run_cycles_d = run_cycles_q + 32'd1;
        end else begin
          run_cycles_d = run_cycles_q;
        end
      end
`ifdef LOADER_DUMP_EN
      FIN: begin
        test_normal_d = 1'b1;
        idx_d         = 9'd0;
        addr_d        = DUMP_BASE;
        state_d       = DUMP_ADDR;
      end
      DUMP_ADDR: begin
        wait_d  = 8'(MEM_RD_LAT);
        state_d = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        if (wait_q <= 8'd1) begin
          out_valid_d = 1'b1;
          out_byte_d  = mem_out[15:8];
          lo_d        = mem_out[7:0];
          state_d     = DUMP_HI;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      DUMP_HI: begin
        if (out_ready) begin out_byte_d = lo_q; state_d = DUMP_LO; end
        else begin state_d = DUMP_HI; end
      end
      DUMP_LO: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == 9'(DUMP_LEN - 1)) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 9'd1;
            addr_d  = DUMP_BASE + 16'(idx_q) + 16'd1;
            state_d = DUMP_ADDR;
          end
        end else begin
          state_d = DUMP_LO;
        end
      end
`else
      FIN: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d inside {IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L});
    busy_d     = (state_d != IDLE);
  end

  // State and output registers; the async reset pulls the core back into reset immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      is_inst_q     <= 1'b0;
      hold_q        <= 8'd0;
      in_ready_q    <= 1'b1;
      test_normal_q <= 1'b1;
      inst_we_q     <= 1'b0;
      data_we_q     <= 1'b0;
      addr_q        <= 16'd0;
      data_q        <= 16'd0;
      cpu_rst_q     <= 1'b0;
      run_cycles_q  <= 32'd0;
      run_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
`ifdef LOADER_DUMP_EN
      idx_q         <= 9'd0;
      wait_q        <= 8'd0;
      lo_q          <= 8'd0;
      out_valid_q   <= 1'b0;
      out_byte_q    <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      is_inst_q     <= is_inst_d;
      hold_q        <= hold_d;
      in_ready_q    <= in_ready_d;
      test_normal_q <= test_normal_d;
      inst_we_q     <= inst_we_d;
      data_we_q     <= data_we_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      cpu_rst_q     <= cpu_rst_d;
      run_cycles_q  <= run_cycles_d;
      run_valid_q   <= run_valid_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
`ifdef LOADER_DUMP_EN
      idx_q         <= idx_d;
      wait_q        <= wait_d;
      lo_q          <= lo_d;
      out_valid_q   <= out_valid_d;
      out_byte_q    <= out_byte_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign test_normal = test_normal_q;
  assign ext_inst_we = inst_we_q;
  assign ext_data_we = data_we_q;
  assign ext_addr    = addr_q;
  assign ext_data    = data_q;
  assign cpu_rst     = cpu_rst_q;
  assign run_cycles  = run_cycles_q;
  assign run_valid   = run_valid_q;
  assign busy        = busy_q;
  assign err         = err_q;
`ifdef LOADER_DUMP_EN
  assign out_valid   = out_valid_q;
  assign out_byte    = out_byte_q;
`else
  // Without the dump path the read-back inputs and dump settings have no consumer.
  logic unused_s;
  assign unused_s  = ^{out_ready, mem_out, DUMP_BASE, 16'(DUMP_LEN), 16'(MEM_RD_LAT)};
  assign out_valid = 1'b0;
  assign out_byte  = 8'd0;
`endif

endmodule
